// File: rtl/instr_loader.sv
// Byte-serial instruction loader: packs UART bytes big-endian into 32-bit words for instruction RAM.
// Optional checksum stage selected by `define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_done,
  output logic [31:0] out_ins_to_mem,
  output logic [31:0] out_addr_debug,
  output logic        out_wea_ram_inst,
  output logic        out_debug_flag,
  output logic        out_load_done,
  output logic        out_overflow,
  output logic        out_chk_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {RECV = 2'd0, WRITE = 2'd1, CHK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {RECV = 2'd0, WRITE = 2'd1, DONE = 2'd3} state_t;
`endif

  localparam logic [31:0] LAST_ADDR = 32'((MAX_WORDS - 1) * 4);

  state_t      r_state;
  state_t      w_next_state;
  logic [23:0] r_shift;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_ins;
  logic [31:0] r_addr;
  logic        r_overflow;

  logic w_is_halt;
  logic w_is_last;
  logic w_write_cont;
  logic w_accept;
  logic w_word_done;
  logic w_restart;

  assign w_is_halt    = (r_ins == HALT_WORD);
  assign w_is_last    = (r_addr == LAST_ADDR);
  assign w_write_cont = !w_is_halt && !w_is_last;
  // A byte arriving during WRITE starts the next word only if loading continues.
  assign w_accept     = in_rx_done &&
                        ((r_state == RECV) || ((r_state == WRITE) && w_write_cont));
  assign w_word_done  = w_accept && (r_byte_cnt == 2'd3);
  assign w_restart    = (r_state == DONE) && in_start;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_chk_err;
  logic       w_chk_byte;

  // The checksum byte may land in the halt word's WRITE cycle as well as in CHK.
  assign w_chk_byte = in_rx_done &&
                      ((r_state == CHK) || ((r_state == WRITE) && w_is_halt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xor     <= 8'h00;
      r_chk_err <= 1'b0;
    end else if (w_restart) begin
      r_xor     <= 8'h00;
      r_chk_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_xor <= r_xor ^ in_rx_data;
      end
      if (w_chk_byte) begin
        r_chk_err <= (in_rx_data != r_xor);
      end
    end
  end

  assign out_chk_err = r_chk_err;
`else
  assign out_chk_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RECV;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RECV: begin
        if (w_word_done) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (w_is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          w_next_state = in_rx_done ? DONE : CHK;
`else
          w_next_state = DONE;
`endif
        end else if (w_is_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (in_rx_done) begin
          w_next_state = DONE;
        end
      end
`endif
      DONE: begin
        if (in_start) begin
          w_next_state = RECV;
        end
      end
      default: w_next_state = RECV;
    endcase
  end

  always_comb begin
    out_wea_ram_inst = (r_state == WRITE);
    out_debug_flag   = (r_state != DONE);
    out_load_done    = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= 24'h000000;
      r_byte_cnt <= 2'd0;
      r_ins      <= 32'h00000000;
      r_addr     <= 32'h00000000;
      r_overflow <= 1'b0;
    end else if (w_restart) begin
      r_shift    <= 24'h000000;
      r_byte_cnt <= 2'd0;
      r_addr     <= 32'h00000000;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift    <= {r_shift[15:0], in_rx_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // The word register only changes on completion, so it is stable through WRITE.
        if (r_byte_cnt == 2'd3) begin
          r_ins <= {r_shift, in_rx_data};
        end
      end
      if (r_state == WRITE) begin
        r_addr <= r_addr + 32'd4;
        if (!w_is_halt && w_is_last) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign out_ins_to_mem = r_ins;
  assign out_addr_debug = r_addr;
  assign out_overflow   = r_overflow;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-depth instance and a MAX_WORDS=2 instance for overflow.
// Expected RAM writes are queued as bytes are driven and popped on every write-enable pulse.
module tb_instr_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        rst_ovf;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_done;

  logic [31:0] m_ins, m_addr, o_ins, o_addr;
  logic        m_wea, m_dbg, m_done, m_ovf, m_chk;
  logic        o_wea, o_dbg, o_done, o_ovf, o_chk;

  int n_pass  = 0;
  int n_total = 0;
  wr_t q_main[$];
  wr_t q_ovf[$];
  logic [31:0] exp_addr;

  instr_loader dut (
    .clk(clk), .reset(reset), .in_start(start), .in_rx_data(rx_data), .in_rx_done(rx_done),
    .out_ins_to_mem(m_ins), .out_addr_debug(m_addr), .out_wea_ram_inst(m_wea),
    .out_debug_flag(m_dbg), .out_load_done(m_done), .out_overflow(m_ovf), .out_chk_err(m_chk)
  );

  instr_loader #(.MAX_WORDS(2)) dut_ovf (
    .clk(clk), .reset(rst_ovf), .in_start(start), .in_rx_data(rx_data), .in_rx_done(rx_done),
    .out_ins_to_mem(o_ins), .out_addr_debug(o_addr), .out_wea_ram_inst(o_wea),
    .out_debug_flag(o_dbg), .out_load_done(o_done), .out_overflow(o_ovf), .out_chk_err(o_chk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_main(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q_main.push_back(e);
  endtask

  task automatic push_ovf(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q_ovf.push_back(e);
  endtask

  // Drives n bytes back-to-back, MSB first; returns on the falling edge after the last byte.
  task automatic send(input logic [63:0] bytes, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx_data = bytes[8*(n-1-i) +: 8];
      rx_done = 1'b1;
      @(negedge clk);
    end
    rx_done = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (m_wea) begin
      check("main_wea_expected", {31'b0, m_wea}, {31'b0, (q_main.size() != 0)});
      if (q_main.size() != 0) begin
        e = q_main.pop_front();
        check("main_data", m_ins, e.data);
        check("main_addr", m_addr, e.addr);
        $display("main write: addr=%h data=%h", m_addr, m_ins);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (o_wea) begin
      check("ovf_wea_expected", {31'b0, o_wea}, {31'b0, (q_ovf.size() != 0)});
      if (q_ovf.size() != 0) begin
        e = q_ovf.pop_front();
        check("ovf_data", o_ins, e.data);
        check("ovf_addr", o_addr, e.addr);
        $display("ovf write: addr=%h data=%h", o_addr, o_ins);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    rst_ovf = 1'b1;
    start   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ins", m_ins, 32'h0);
    check("rst_addr", m_addr, 32'h0);
    check("rst_wea", {31'b0, m_wea}, 32'h0);
    check("rst_dbg", {31'b0, m_dbg}, 32'h1);
    check("rst_done", {31'b0, m_done}, 32'h0);
    check("rst_ovf", {31'b0, m_ovf}, 32'h0);
    check("rst_chk", {31'b0, m_chk}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("dbg_recv", {31'b0, m_dbg}, 32'h1);

    // Two words back-to-back; the 5th byte arrives during the first WRITE.
    push_main(32'h0, 32'hAC030000);
    push_main(32'h4, 32'hAC033333);
    send(64'hAC030000_AC033333, 8);
    check("lat_b2b", {31'b0, m_wea}, 32'h1);
    @(negedge clk);
    check("addr_adv", m_addr, 32'h8);

    // Asynchronous reset in the middle of a word.
    send(64'hAABB, 2);
    #2 reset = 1'b1;
    #1 check("async_ins", m_ins, 32'h0);
    check("async_addr", m_addr, 32'h0);
    #1 reset = 1'b0;
    push_main(32'h0, 32'h11223344);
    send(64'h11223344, 4);
    check("lat_after_rst", {31'b0, m_wea}, 32'h1);
    @(negedge clk);
    check("addr_after_rst", m_addr, 32'h4);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    push_main(32'h0, 32'hAC030000);
    push_main(32'h4, 32'hFFFFFFFF);
    send(64'hAC030000_FFFFFFFF, 8);
    @(negedge clk);
    check("chk_dbg", {31'b0, m_dbg}, 32'h1);
    check("chk_not_done", {31'b0, m_done}, 32'h0);
    send(64'hAF, 1);
    check("chk_good_done", {31'b0, m_done}, 32'h1);
    check("chk_good_err", {31'b0, m_chk}, 32'h0);
    check("chk_good_dbg", {31'b0, m_dbg}, 32'h0);
    pulse_start();
    push_main(32'h0, 32'hAC030000);
    push_main(32'h4, 32'hFFFFFFFF);
    send(64'hAC030000_FFFFFFFF, 8);
    @(negedge clk);
    send(64'h00, 1);
    check("chk_bad_err", {31'b0, m_chk}, 32'h1);
    check("chk_bad_done", {31'b0, m_done}, 32'h1);
    exp_addr = 32'h8;
`else
    push_main(32'h0, 32'hFFFFFFFF);
    send(64'hFFFFFFFF, 4);
    check("lat_halt", {31'b0, m_wea}, 32'h1);
    @(negedge clk);
    check("halt_done", {31'b0, m_done}, 32'h1);
    check("halt_dbg", {31'b0, m_dbg}, 32'h0);
    check("halt_chk_tied", {31'b0, m_chk}, 32'h0);
    exp_addr = 32'h4;
`endif

    // Bytes in DONE are ignored.
    send(64'h12345678, 4);
    repeat (2) @(negedge clk);
    check("done_hold", {31'b0, m_done}, 32'h1);
    check("done_addr", m_addr, exp_addr);

    pulse_start();
    check("start_done", {31'b0, m_done}, 32'h0);
    check("start_dbg", {31'b0, m_dbg}, 32'h1);
    check("start_addr", m_addr, 32'h0);
    check("start_ovf", {31'b0, m_ovf}, 32'h0);
    check("start_chk", {31'b0, m_chk}, 32'h0);

    // A start pulse mid-word (not in DONE) must not disturb the word.
    push_main(32'h0, 32'h01020304);
    send(64'h0102, 2);
    pulse_start();
    send(64'h0304, 2);
    check("lat_restart", {31'b0, m_wea}, 32'h1);
    @(negedge clk);
    check("addr_restart", m_addr, 32'h4);

    // Overflow on the two-word instance; the main instance is parked in reset.
    reset   = 1'b1;
    rst_ovf = 1'b0;
    push_ovf(32'h0, 32'h00000001);
    push_ovf(32'h4, 32'h00000002);
    send(64'h00000001_00000002, 8);
    check("ovf_lat", {31'b0, o_wea}, 32'h1);
    @(negedge clk);
    check("ovf_flag", {31'b0, o_ovf}, 32'h1);
    check("ovf_done", {31'b0, o_done}, 32'h1);
    check("ovf_dbg", {31'b0, o_dbg}, 32'h0);
    send(64'hDEADBEEF, 4);
    repeat (3) @(negedge clk);
    check("ovf_hold", {31'b0, o_done}, 32'h1);

    check("main_sb_empty", 32'(q_main.size()), 32'h0);
    check("ovf_sb_empty", 32'(q_ovf.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
